// File: rtl/pipeline_wb_trace_buffer.sv
// Retire-trace FIFO: captures MEM/WB writebacks (rd, data, cycle stamp) and
// returns them oldest-first through a registered one-cycle pop port.
module pipeline_wb_trace_buffer #(
  parameter int DATA_W  = 64,
  parameter int REG_W   = 5,
  parameter int DEPTH   = 16,
  parameter int STAMP_W = 32,
  parameter int DROP_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     mode_circular,
  input  logic                     filter_x0,
  input  logic                     wb_valid,
  input  logic [REG_W-1:0]         wb_rd,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [REG_W-1:0]         rd_reg,
  output logic [DATA_W-1:0]        rd_data,
  output logic [STAMP_W-1:0]       rd_stamp,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic [DROP_W-1:0]        dropped
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int EW    = REG_W + DATA_W + STAMP_W;

  logic [EW-1:0]      mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [STAMP_W-1:0] stamp;

  logic cap, pop, store, lose, inc, dec;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    sat_inc = (v == {DROP_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  always_comb begin
    cap   = enable & wb_valid & ~(filter_x0 & (wb_rd == '0));
    pop   = rd_en & ~empty;
    // A pop on a full buffer frees the slot the new event lands in.
    store = cap & (~full | pop | mode_circular);
    lose  = cap & full & ~pop;
    inc   = cap & ~full & ~pop;
    dec   = pop & ~cap;
  end

  // Entry storage carries data only; validity lives in the pointers/count.
  always_ff @(posedge clk) begin
    if (!reset && store)
      mem[wr_ptr] <= {wb_rd, wb_data, stamp};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      stamp    <= '0;
      overflow <= 1'b0;
      dropped  <= '0;
      rd_valid <= 1'b0;
      rd_reg   <= '0;
      rd_data  <= '0;
      rd_stamp <= '0;
    end else begin
      stamp    <= stamp + 1'b1;
      rd_valid <= pop;
      if (pop)
        {rd_reg, rd_data, rd_stamp} <= mem[rd_ptr];
      if (store)
        wr_ptr <= wr_ptr + 1'b1;
      // Circular overwrite retires the oldest entry along with the write.
      if (pop || (lose && mode_circular))
        rd_ptr <= rd_ptr + 1'b1;
      if (inc)
        count <= count + 1'b1;
      else if (dec)
        count <= count - 1'b1;
      if (lose) begin
        overflow <= 1'b1;
        dropped  <= sat_inc(dropped);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_wb_trace_buffer.sv
// Scoreboard bench for pipeline_wb_trace_buffer: a queue-based reference model
// predicts pops and status; a negedge monitor compares the DUT against it.
module tb_pipeline_wb_trace_buffer;
  localparam int DATA_W  = 64;
  localparam int REG_W   = 5;
  localparam int DEPTH   = 16;
  localparam int STAMP_W = 32;
  localparam int DROP_W  = 4;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1, enable = 1'b0, mode_circular = 1'b0, filter_x0 = 1'b0;
  logic wb_valid = 1'b0, rd_en = 1'b0;
  logic [REG_W-1:0]   wb_rd = '0;
  logic [DATA_W-1:0]  wb_data = '0;
  logic               rd_valid;
  logic [REG_W-1:0]   rd_reg;
  logic [DATA_W-1:0]  rd_data;
  logic [STAMP_W-1:0] rd_stamp;
  logic [$clog2(DEPTH):0] count;
  logic full, empty, overflow;
  logic [DROP_W-1:0] dropped;

  pipeline_wb_trace_buffer #(
    .DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH), .STAMP_W(STAMP_W), .DROP_W(DROP_W)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode_circular(mode_circular),
    .filter_x0(filter_x0), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .rd_en(rd_en), .rd_valid(rd_valid), .rd_reg(rd_reg), .rd_data(rd_data),
    .rd_stamp(rd_stamp), .count(count), .full(full), .empty(empty),
    .overflow(overflow), .dropped(dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [REG_W-1:0]   r;
    logic [DATA_W-1:0]  d;
    logic [STAMP_W-1:0] s;
  } ent_t;

  // Reference model state
  ent_t fifo_q[$];
  ent_t exp_q[$];
  ent_t hold;
  logic [STAMP_W-1:0] m_stamp;
  logic m_ovf;
  int   m_drop;
  bit   started = 0;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_edge();
    ent_t e;
    bit cap, pop;
    if (reset) begin
      fifo_q.delete();
      exp_q.delete();
      hold = '{r: '0, d: '0, s: '0};
      m_stamp = '0;
      m_ovf = 1'b0;
      m_drop = 0;
      return;
    end
    cap = enable && wb_valid && !(filter_x0 && wb_rd == 0);
    pop = rd_en && fifo_q.size() > 0;
    if (pop) begin
      hold = fifo_q.pop_front();
      exp_q.push_back(hold);
    end
    if (cap) begin
      e = '{r: wb_rd, d: wb_data, s: m_stamp};
      if (fifo_q.size() < DEPTH) fifo_q.push_back(e);
      else begin
        if (mode_circular) begin
          void'(fifo_q.pop_front());
          fifo_q.push_back(e);
        end
        m_ovf = 1'b1;
        if (m_drop < DROP_MAX) m_drop++;
      end
    end
    m_stamp = m_stamp + 1;
  endfunction

  task automatic step(input logic r, input logic en, input logic circ, input logic fx,
                      input logic v, input logic [REG_W-1:0] rd, input logic [DATA_W-1:0] d,
                      input logic re);
    @(negedge clk);
    #1;
    reset = r; enable = en; mode_circular = circ; filter_x0 = fx;
    wb_valid = v; wb_rd = rd; wb_data = d; rd_en = re;
    @(posedge clk);
    model_edge();
    if (r) started = 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, mode_circular, filter_x0, 0, 0, 0, 0);
  endtask

  task automatic pops(input int n);
    for (int i = 0; i < n; i++) step(0, 1, mode_circular, filter_x0, 0, 0, 0, 1);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: consume predicted pops whenever the DUT presents output.
  always @(negedge clk) begin
    ent_t e;
    if (started) begin
      chk("rd_valid", rd_valid, exp_q.size() > 0);
      if (rd_valid && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pop_reg", rd_reg, e.r);
        chk("pop_data", rd_data, e.d);
        chk("pop_stamp", rd_stamp, e.s);
      end else begin
        exp_q.delete();
        chk("hold_reg", rd_reg, hold.r);
        chk("hold_data", rd_data, hold.d);
        chk("hold_stamp", rd_stamp, hold.s);
      end
      chk("count", count, fifo_q.size());
      chk("full", full, fifo_q.size() == DEPTH);
      chk("empty", empty, fifo_q.size() == 0);
      chk("overflow", overflow, m_ovf);
      chk("dropped", dropped, m_drop);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout reached without completing stimulus");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    // First event at stamp 3, popped next cycle
    idle(3);
    step(0, 1, 0, 0, 1, 5, 64'hDEAD_BEEF, 0);
    chk("first_stamp_model", fifo_q[0].s, 3);
    pops(1);
    idle(2);

    // x0 filtering on then off
    for (int f = 1; f >= 0; f--) begin
      step(0, 1, 0, f[0], 1, 0, 64'h10, 0);
      step(0, 1, 0, f[0], 1, 1, 64'h11, 0);
      step(0, 1, 0, f[0], 1, 0, 64'h12, 0);
      step(0, 1, 0, f[0], 1, 2, 64'h13, 0);
      idle(1);
      pops(5);
    end

    // Stop then circular mode: 20 captures into 16 slots
    for (int m = 0; m < 2; m++) begin
      do_reset();
      for (int i = 1; i <= 20; i++) step(0, 1, m[0], 0, 1, REG_W'(i), DATA_W'(i), 0);
      idle(1);
      if (m == 1) step(0, 1, 1, 0, 1, 9, 64'd99, 1);
      pops(17);
      idle(1);
    end

    // Reset mid-operation with 7 entries and a pop request
    for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 1, 3, DATA_W'(100 + i), 0);
    step(1, 1, 0, 0, 1, 3, 64'd77, 1);
    idle(3);
    pops(2);

    // Saturate dropped in stop mode
    for (int i = 0; i < DEPTH + DROP_MAX + 5; i++) step(0, 1, 0, 0, 1, 7, DATA_W'(i), 0);
    pops(3);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      logic r, en, circ, fx, v, re;
      logic [REG_W-1:0] rd;
      logic [DATA_W-1:0] d;
      r    = ($urandom_range(0, 299) == 0);
      en   = ($urandom_range(0, 9) != 0);
      circ = (((i / 200) % 2) == 1) ^ ($urandom_range(0, 19) == 0);
      fx   = $urandom_range(0, 1);
      v    = ($urandom_range(0, 9) < 6);
      rd   = ($urandom_range(0, 3) == 0) ? '0 : REG_W'($urandom);
      d    = {$urandom, $urandom};
      re   = ($urandom_range(0, 9) < ((i / 300) % 2 == 0 ? 3 : 7));
      step(r, en, circ, fx, v, rd, d, re);
    end
    pops(DEPTH + 2);
    idle(2);
    @(negedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
